// File: rtl/cskipa_pkg.sv
// Shared sizing for the carry-skip adder issue stage: default operand width,
// default FIFO depth, and the width of the FIFO occupancy count.
package cskipa_pkg;

  localparam int unsigned CSKIPA_WIDTH = 24;
  localparam int unsigned CSKIPA_DEPTH = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cskipa_opfifo.sv
// Circular operand-pair FIFO feeding the adder issue pipeline.
// The head entry is presented combinationally; a pop simply advances the read pointer.
module cskipa_opfifo
  import cskipa_pkg::*;
#(
  parameter int unsigned WIDTH = CSKIPA_WIDTH,
  parameter int unsigned DEPTH = CSKIPA_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_a,
  input  logic [WIDTH-1:0]               i_b,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_head_a,
  output logic [WIDTH-1:0]               o_head_b,
  output logic [occ_width(DEPTH)-1:0]    o_count,
  output logic                           o_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = occ_width(DEPTH);

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_ready;
  logic w_push;
  logic w_pop;

  assign w_ready = (r_count < CW'(DEPTH));
  assign w_push  = i_push && w_ready;
  assign w_pop   = i_pop && (r_count != '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem_a[r_wr_ptr] <= i_a;
      r_mem_b[r_wr_ptr] <= i_b;
    end
  end

  assign o_head_a = r_mem_a[r_rd_ptr];
  assign o_head_b = r_mem_b[r_rd_ptr];
  assign o_count  = r_count;
  assign o_ready  = w_ready;

endmodule

// File: rtl/cskipa_issue.sv
// Issue stage for an external carry-skip adder: FIFO -> OP (adder terms) -> RES (registered sum/carry).
// The adder itself lives outside this block; its sum and carry come back on adder_sum/adder_cout.
module cskipa_issue
  import cskipa_pkg::*;
#(
  parameter int unsigned WIDTH = CSKIPA_WIDTH,
  parameter int unsigned DEPTH = CSKIPA_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  output logic [WIDTH-1:0]               i_add_term1,
  output logic [WIDTH-1:0]               i_add_term2,
  input  logic [WIDTH-1:0]               adder_sum,
  input  logic                           adder_cout,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_sum,
  output logic                           out_cout,
  output logic [occ_width(DEPTH)-1:0]    fifo_count
);

  localparam int unsigned CW = occ_width(DEPTH);

  logic             r_op_valid;
  logic [WIDTH-1:0] r_term1;
  logic [WIDTH-1:0] r_term2;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [CW-1:0]    w_count;
  logic             w_fifo_ready;
  logic             w_res_load;
  logic             w_op_load;

  cskipa_opfifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_opfifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (in_valid),
    .i_a      (in_a),
    .i_b      (in_b),
    .i_pop    (w_op_load),
    .o_head_a (w_head_a),
    .o_head_b (w_head_b),
    .o_count  (w_count),
    .o_ready  (w_fifo_ready)
  );

  // RES advances when it is empty or being drained; OP refills whenever RES takes its value.
  assign w_res_load = r_op_valid && (!r_out_valid || out_ready);
  assign w_op_load  = (w_count != '0) && (!r_op_valid || w_res_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_valid  <= 1'b0;
      r_term1     <= '0;
      r_term2     <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      if (w_op_load) begin
        r_op_valid <= 1'b1;
        r_term1    <= w_head_a;
        r_term2    <= w_head_b;
      end else if (w_res_load) begin
        r_op_valid <= 1'b0;
      end

      if (w_res_load) begin
        r_out_valid <= 1'b1;
        r_sum       <= adder_sum;
        r_cout      <= adder_cout;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_fifo_ready;
  assign fifo_count  = w_count;
  assign i_add_term1 = r_term1;
  assign i_add_term2 = r_term2;
  assign out_valid   = r_out_valid;
  assign out_sum     = r_sum;
  assign out_cout    = r_cout;

endmodule

// File: tb/tb_cskipa_issue.sv
// Scoreboard bench for cskipa_issue with a behavioural stand-in for the external 24-bit adder.
module tb_cskipa_issue;

  localparam int unsigned W = 24;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W-1:0]  i_add_term1;
  logic [W-1:0]  i_add_term2;
  logic [W-1:0]  adder_sum;
  logic          adder_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  // External adder: full-width sum with carry-out.
  assign {adder_cout, adder_sum} = {1'b0, i_add_term1} + {1'b0, i_add_term2};

  cskipa_issue #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .i_add_term1 (i_add_term1),
    .i_add_term2 (i_add_term2),
    .adder_sum   (adder_sum),
    .adder_cout  (adder_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_cout    (out_cout),
    .fifo_count  (fifo_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_n    = 0;
  int          n_out    = 0;
  logic [W:0]  exp_q[$];
  int          pop_cyc[$];
  logic        stall_pend = 1'b0;
  logic [W:0]  stall_val;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: every accepted pair yields its full-width sum, in acceptance order.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
  end

  // Monitor: compares each delivered result and checks the result is held while stalled.
  always @(negedge clk) begin
    logic [W:0] e;
    if (stall_pend) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_hold", 64'({out_cout, out_sum}), 64'(stall_val));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_result: got 0x%0h expected no result (cycle %0d)",
                 {out_cout, out_sum}, cyc_n);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({out_cout, out_sum}), 64'(e));
      end
      n_out++;
      pop_cyc.push_back(cyc_n);
    end
    stall_pend = out_valid && !out_ready && !rst;
    stall_val  = {out_cout, out_sum};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      cyc();
      if (acc) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 24'h7FFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'({out_cout, out_sum}), 64'd0);
    check("rst_terms", 64'({i_add_term1, i_add_term2}), 64'd0);
    rst = 1'b0;

    // Single pair latency and wrap-around carry
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 24'h000001; in_b = 24'hFFFFFF;
    cyc();
    in_valid = 1'b0;
    check("lat_n0_valid", 64'(out_valid), 64'd0);
    cyc();
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    check("lat_n1_terms", 64'({i_add_term1, i_add_term2}), 64'h000001_FFFFFF);
    cyc();
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_sum", 64'({out_cout, out_sum}), 64'h1_000000);
    cyc();
    check("lat_n3_valid", 64'(out_valid), 64'd0);

    // Streaming 8 back-to-back
    base = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op());
    in_valid = 1'b0;
    repeat (4) cyc();
    check("stream_count", 64'(pop_cyc.size() - base), 64'd8);
    if (pop_cyc.size() >= base + 8)
      check("stream_back_to_back", 64'(pop_cyc[base+7] - pop_cyc[base]), 64'd7);

    // Full backpressure: 6 accepted, 7th refused
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(rnd_op(), rnd_op());
    in_valid = 1'b1; in_a = 24'h123456; in_b = 24'h654321;
    for (int i = 0; i < 3; i++) begin
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_count", 64'(fifo_count), 64'd4);
      check("full_out_valid", 64'(out_valid), 64'd1);
      check("full_op_valid", 64'(dut.r_op_valid), 64'd1);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-stream with a push on the reset cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
    rst = 1'b1; in_valid = 1'b1; in_a = 24'hABCDEF; in_b = 24'h111111;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(fifo_count), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    n0 = n_out;
    out_ready = 1'b1;
    repeat (6) cyc();
    check("midrst_no_stale", 64'(n_out - n0), 64'd0);

    // Simultaneous push and pop at count 2, full-width carry propagation
    out_ready = 1'b0;
    send(rnd_op(), rnd_op());
    send(rnd_op(), rnd_op());
    send(rnd_op(), rnd_op());
    send(24'h7FFFFF, 24'h000001);
    check("simul_pre_count", 64'(fifo_count), 64'd2);
    out_ready = 1'b1;
    send(rnd_op(), rnd_op());
    check("simul_count", 64'(fifo_count), 64'd2);
    in_valid = 1'b0;
    repeat (8) cyc();
    check("simul_drain", 64'(exp_q.size()), 64'd0);

    // Randomised traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rnd_op();
      in_b      = rnd_op();
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = (i == 200);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) cyc();
    check("final_drain", 64'(exp_q.size()), 64'd0);
    check("final_count", 64'(fifo_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
